// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline controller: FSM state encoding
// and the bundle of enable/clear controls driven to PC and pipeline registers.
package pipe_ctrl_pkg;

   localparam int unsigned MULDIV_LAT_DEFAULT = 4;
   localparam int unsigned CNT_W              = 4;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_MULDIV = 2'd1,
      ST_HALT   = 2'd2
   } state_e;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_clr;
      logic idex_en;
      logic idex_clr;
      logic exmem_en;
      logic exmem_clr;
      logic memwb_en;
   } ctrl_t;

   // Free-flowing pipeline: everything advances, nothing is flushed.
   localparam ctrl_t CTRL_DEFAULT = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_clr: 1'b0,
                                      idex_en: 1'b1, idex_clr: 1'b0, exmem_en: 1'b1,
                                      exmem_clr: 1'b0, memwb_en: 1'b1};

   // Mul/div in EX: front end frozen, a bubble flows into MEM behind it.
   localparam ctrl_t CTRL_FREEZE  = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_clr: 1'b0,
                                      idex_en: 1'b0, idex_clr: 1'b0, exmem_en: 1'b1,
                                      exmem_clr: 1'b1, memwb_en: 1'b1};

   localparam ctrl_t CTRL_HOLD    = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination feeds a source of
// the instruction in ID. Register $0 never creates a dependency.
module hazard_detect
(
   input  logic [4:0] id_rs_i,
   input  logic [4:0] id_rt_i,
   input  logic       id_use_rs_i,
   input  logic       id_use_rt_i,
   input  logic       ex_mem_to_reg_i,
   input  logic       ex_reg_write_i,
   input  logic [4:0] ex_wb_reg_i,
   output logic       load_use_o
);

   logic rs_match;
   logic rt_match;

   assign rs_match   = id_use_rs_i && (id_rs_i == ex_wb_reg_i);
   assign rt_match   = id_use_rt_i && (id_rt_i == ex_wb_reg_i);
   assign load_use_o = ex_mem_to_reg_i && ex_reg_write_i && (ex_wb_reg_i != 5'd0)
                       && (rs_match || rt_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller: load-use bubbles, branch flushes, multi-cycle
// mul/div freeze and syscall halt, plus a saturating stall-cycle counter.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int unsigned MULDIV_LAT = MULDIV_LAT_DEFAULT
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ID_rs,
   input  logic [4:0]  ID_rt,
   input  logic        ID_UseRs,
   input  logic        ID_UseRt,
   input  logic        EX_MemtoReg,
   input  logic        EX_RegWrite,
   input  logic [4:0]  EX_WbRegNum,
   input  logic        EX_BranchTaken,
   input  logic        EX_MulDiv,
   input  logic        EX_SYSCALL,
   input  logic        go,
   output logic        PC_EN,
   output logic        IFID_EN,
   output logic        IFID_CLR,
   output logic        IDEX_EN,
   output logic        IDEX_CLR,
   output logic        EXMEM_EN,
   output logic        EXMEM_CLR,
   output logic        MEMWB_EN,
   output logic        halted,
   output logic [15:0] stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_LAT - 2);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               serviced_q, serviced_d;
   logic [15:0]        stall_cnt_q;
   ctrl_t              ctrl;
   logic               load_use;

   hazard_detect u_hazard_detect (
      .id_rs_i         (ID_rs),
      .id_rt_i         (ID_rt),
      .id_use_rs_i     (ID_UseRs),
      .id_use_rt_i     (ID_UseRt),
      .ex_mem_to_reg_i (EX_MemtoReg),
      .ex_reg_write_i  (EX_RegWrite),
      .ex_wb_reg_i     (EX_WbRegNum),
      .load_use_o      (load_use)
   );

   // The entry cycle plus every MULDIV cycle (count LAT-2 down to 0) is frozen,
   // giving MULDIV_LAT frozen cycles; the mul/div then leaves EX in the first
   // RUN cycle, where the serviced flag stops it from re-triggering.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      ctrl       = CTRL_DEFAULT;
      state_d    = state_q;
      cnt_d      = cnt_q;
      serviced_d = serviced_q;

      unique case (state_q)
         ST_RUN: begin
            if (EX_SYSCALL) begin
               ctrl    = CTRL_HOLD;
               state_d = ST_HALT;
            end else if (EX_MulDiv && !serviced_q) begin
               ctrl       = CTRL_FREEZE;
               state_d    = ST_MULDIV;
               cnt_d      = CNT_LOAD;
               serviced_d = 1'b1;
            end else if (EX_BranchTaken) begin
               ctrl.ifid_clr = 1'b1;
               ctrl.idex_clr = 1'b1;
            end else if (load_use) begin
               ctrl.pc_en    = 1'b0;
               ctrl.ifid_en  = 1'b0;
               ctrl.idex_clr = 1'b1;
            end
            if (ctrl.idex_en) begin
               serviced_d = 1'b0;
            end
         end
         ST_MULDIV: begin
            ctrl = CTRL_FREEZE;
            if (cnt_q == '0) begin
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_HALT: begin
            if (go) begin
               state_d = ST_RUN;
            end else begin
               ctrl = CTRL_HOLD;
            end
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         cnt_q       <= '0;
         serviced_q  <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so all registers update together.
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         serviced_q <= serviced_d;
         if (!ctrl.pc_en && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
         end
      end
   end

   assign PC_EN     = ctrl.pc_en;
   assign IFID_EN   = ctrl.ifid_en;
   assign IFID_CLR  = ctrl.ifid_clr;
   assign IDEX_EN   = ctrl.idex_en;
   assign IDEX_CLR  = ctrl.idex_clr;
   assign EXMEM_EN  = ctrl.exmem_en;
   assign EXMEM_CLR = ctrl.exmem_clr;
   assign MEMWB_EN  = ctrl.memwb_en;
   assign halted    = (state_q == ST_HALT);
   assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter MULDIV_LAT, default 4: EX-stage occupancy in cycles of a multiply/divide (legal range 2..15).
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have ports ID_rs and ID_rt, input, 5 bits each: source register numbers of the instruction in ID.
REQ-005 SHALL have ports ID_UseRs and ID_UseRt, input, 1 bit each: ID instruction reads rs / rt.
REQ-006 SHALL have ports EX_MemtoReg and EX_RegWrite, input, 1 bit each: the EX instruction is a load / writes a register.
REQ-007 SHALL have port EX_WbRegNum, input, 5 bits: destination register of the EX instruction.
REQ-008 SHALL have port EX_BranchTaken, input, 1 bit: branch or jump resolved taken in EX.
REQ-009 SHALL have port EX_MulDiv, input, 1 bit: the EX instruction is mult/multu/div/divu.
REQ-010 SHALL have port EX_SYSCALL, input, 1 bit: the EX instruction is a halting syscall.
REQ-011 SHALL have port go, input, 1 bit: resume from halt.
REQ-012 SHALL have outputs PC_EN, IFID_EN, IFID_CLR, IDEX_EN, IDEX_CLR, EXMEM_EN, EXMEM_CLR and MEMWB_EN, 1 bit each: enable and synchronous-clear controls for PC and the pipeline registers.
REQ-013 SHALL have output halted, 1 bit: high in HALT.
REQ-014 SHALL have output stall_cnt, 16 bits: saturating count of cycles with PC_EN=0.

Function
REQ-015 SHALL implement FSM states RUN, MULDIV, HALT; outputs are combinational from state and inputs.
REQ-016 Default (RUN, no event): all EN=1, all CLR=0.
REQ-017 Load-use hazard SHALL be EX_MemtoReg & EX_RegWrite & EX_WbRegNum!=0 & ((ID_UseRs & ID_rs==EX_WbRegNum) | (ID_UseRt & ID_rt==EX_WbRegNum)).
REQ-018 RUN, load-use: PC_EN=0, IFID_EN=0, IDEX_CLR=1; other outputs default; exactly one bubble per hazard.
REQ-019 RUN, EX_BranchTaken: IFID_CLR=1, IDEX_CLR=1, PC_EN=1; overrides load-use in the same cycle.
REQ-020 RUN, EX_MulDiv (not already serviced): next state MULDIV; counter loaded with MULDIV_LAT-2; this cycle PC_EN=IFID_EN=IDEX_EN=0, EXMEM_CLR=1.
REQ-021 MULDIV: PC_EN=IFID_EN=IDEX_EN=0, EXMEM_CLR=1; decrement each cycle; at count 0, return to RUN with all EN=1 in that cycle so the mul/div leaves EX; total freeze = MULDIV_LAT cycles.
REQ-022 A serviced flag SHALL block re-entry to MULDIV for the same EX instruction; it clears when IDEX_EN=1 in RUN.
REQ-023 RUN, EX_SYSCALL: next state HALT; this cycle all EN=0 (instruction held in EX).
REQ-024 HALT: all EN=0, all CLR=0, halted=1; go=1 returns to RUN with default outputs that cycle; go in other states is ignored.
REQ-025 Priority within RUN: SYSCALL > MulDiv > BranchTaken > load-use.
REQ-026 stall_cnt SHALL increment on every cycle with PC_EN=0 and saturate at 0xFFFF.

Reset
REQ-027 rst=1 SHALL immediately force state RUN, counter 0, serviced flag 0 and stall_cnt 0; outputs then follow RUN equations.
REQ-028 Reset mid-MULDIV or mid-HALT SHALL abandon the operation without residual stall.

Structure
REQ-029 Package pipe_ctrl_pkg SHALL hold the state enum and the MULDIV_LAT default.
REQ-030 The load-use compare SHALL be a combinational sub-module, hazard_detect.

Verification
REQ-031 Load-use: EX lw $5, ID uses rs=5 -> one cycle PC_EN=0, IDEX_CLR=1; stall_cnt=1.
REQ-032 Destination $0: EX_WbRegNum=0 with matching ID_rs=0 -> no stall.
REQ-033 Branch plus load-use in the same cycle -> IFID_CLR=IDEX_CLR=1, PC_EN=1.
REQ-034 EX_MulDiv held with MULDIV_LAT=4 -> exactly 4 cycles of IDEX_EN=0 and EXMEM_CLR=1, then RUN; stall_cnt=4.
REQ-035 SYSCALL -> halted=1 and all EN=0 for 10 cycles; go pulse -> RUN next edge.
REQ-036 rst asserted at MULDIV count 1 -> RUN immediately, stall_cnt=0, outputs at defaults.
